// File: rtl/game_state_ctrl.sv
// Game-flow controller: filters PS/2 break codes into make-code pulses and sequences
// IDLE -> READY (seconds countdown) -> PLAY -> OVER for the downstream timers.
module game_state_ctrl #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned READY_SEC  = 3,
  parameter logic [7:0]  KEY_START  = 8'h5A,
  parameter logic [7:0]  KEY_ABORT  = 8'h76,
  parameter logic [7:0]  BREAK_CODE = 8'hF0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_key_pressed,
  input  logic [7:0] i_ps2_key_data,
  input  logic       i_hit,
  input  logic       i_win,
  output logic [2:0] o_game_status,
  output logic       o_key_valid,
  output logic [7:0] o_key_code,
  output logic [3:0] o_countdown,
  output logic       o_result_win
);

  localparam int unsigned TickW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(CLK_FREQ - 1);
  localparam logic [3:0] CountLoad = 4'(READY_SEC);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReady = 2'd1,
    StPlay  = 2'd2,
    StOver  = 2'd3
  } state_e;

  state_e           r_state, w_state_d;
  logic             r_break, w_break_d;
  logic             r_key_valid;
  logic [7:0]       r_key_code;
  logic [3:0]       r_count, w_count_d;
  logic [TickW-1:0] r_tick, w_tick_d;
  logic             r_result, w_result_d;

  logic             w_accept;
  logic             w_start;
  logic             w_abort;

  // A make code is accepted only when no break prefix is pending.
  always_comb begin
    w_accept  = i_ps2_key_pressed && !r_break && (i_ps2_key_data != BREAK_CODE);
    w_start   = w_accept && (i_ps2_key_data == KEY_START);
    w_abort   = w_accept && (i_ps2_key_data == KEY_ABORT);
    w_break_d = r_break;
    if (i_ps2_key_pressed) begin
      w_break_d = !r_break && (i_ps2_key_data == BREAK_CODE);
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_tick_d   = '0;
    w_result_d = r_result;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = StReady;
          w_count_d = CountLoad;
        end
      end
      StReady: begin
        w_tick_d = r_tick + 1'b1;
        if (r_tick == TickMax) begin
          w_tick_d  = '0;
          w_count_d = r_count - 1'b1;
          if (r_count == 4'd1) begin
            w_state_d = StPlay;
          end
        end
      end
      StPlay: begin
        if (i_hit) begin
          w_state_d  = StOver;
          w_result_d = 1'b0;
        end else if (i_win) begin
          w_state_d  = StOver;
          w_result_d = 1'b1;
        end
      end
      StOver: begin
        if (w_start) begin
          w_state_d = StReady;
          w_count_d = CountLoad;
        end
      end
    endcase
    // Abort overrides everything else, but leaves the last result visible.
    if (w_abort) begin
      w_state_d  = StIdle;
      w_count_d  = '0;
      w_tick_d   = '0;
      w_result_d = r_result;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_break     <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_code  <= 8'h00;
      r_count     <= 4'd0;
      r_tick      <= '0;
      r_result    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_break     <= w_break_d;
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= i_ps2_key_data;
      end
      r_count     <= w_count_d;
      r_tick      <= w_tick_d;
      r_result    <= w_result_d;
    end
  end

  assign o_game_status = {1'b0, r_state};
  assign o_key_valid   = r_key_valid;
  assign o_key_code    = r_key_code;
  assign o_countdown   = r_count;
  assign o_result_win  = r_result;

endmodule
